// File: rtl/pulse_spacer_fast.sv
// Fast-domain pacing stage ahead of the fast-to-slow pulse synchronizer.
// It queues event strobes and re-issues them as single pulses spaced GAP_CYCLES apart.
module pulse_spacer_fast #(
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned   GW         = $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t           w_state;
  logic [GW-1:0]    r_gap_cnt;
  logic [GW-1:0]    w_gap_nxt;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_nxt;
  logic             r_pulse;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_issue;
  logic             w_full;
  logic             w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt <= '0;
      r_pending <= '0;
      r_pulse   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_gap_cnt <= w_gap_nxt;
      r_pending <= w_pending_nxt;
      r_pulse   <= w_issue;
      r_ovf     <= w_ovf_nxt;
    end
  end

  // The gap counter itself is the state: zero means idle, anything else is a running gap.
  always_comb begin
    w_state       = (r_gap_cnt == '0) ? S_IDLE : S_GAP;
    w_issue       = (w_state == S_IDLE) && !flush && ((r_pending != '0) || pulse_in);
    w_full        = &r_pending;
    w_drop        = w_full && pulse_in && !w_issue && !flush;

    w_gap_nxt     = r_gap_cnt;
    if (w_issue)
      w_gap_nxt = GAP_RELOAD;
    else if (w_state == S_GAP)
      w_gap_nxt = r_gap_cnt - GW'(1);

    // A strobe arriving on an issue cycle replaces the issued event, so the count holds.
    w_pending_nxt = r_pending;
    if (flush)
      w_pending_nxt = '0;
    else if (pulse_in && !w_issue && !w_full)
      w_pending_nxt = r_pending + CNT_W'(1);
    else if (w_issue && !pulse_in)
      w_pending_nxt = r_pending - CNT_W'(1);

    w_ovf_nxt     = r_ovf;
    if (w_drop)
      w_ovf_nxt = 1'b1;
    else if (clr_ovf)
      w_ovf_nxt = 1'b0;
  end

  always_comb begin
    pulse_out = r_pulse;
    pending   = r_pending;
    overflow  = r_ovf;
    busy      = (r_pending != '0) || (r_gap_cnt != '0);
  end

endmodule

// File: tb/tb_pulse_spacer_fast.sv
// Directed bench for pulse_spacer_fast: a default instance (CNT_W=4) and a
// narrow-counter instance (CNT_W=2) for saturation and overflow behaviour.
module tb_pulse_spacer_fast;

  logic       clk = 1'b0;

  logic       a_rst, a_pulse, a_flush, a_clr;
  logic       a_po, a_busy, a_ovf;
  logic [3:0] a_pend;
  logic [6:0] a_st;

  logic       b_rst, b_pulse, b_flush, b_clr;
  logic       b_po, b_busy, b_ovf;
  logic [1:0] b_pend;
  logic [4:0] b_st;

  int vectors     = 0;
  int miscompares = 0;

  assign a_st = {a_po, a_pend, a_busy, a_ovf};
  assign b_st = {b_po, b_pend, b_busy, b_ovf};

  always #5 clk = ~clk;

  pulse_spacer_fast #(.GAP_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(a_rst), .pulse_in(a_pulse), .flush(a_flush), .clr_ovf(a_clr),
    .pulse_out(a_po), .pending(a_pend), .busy(a_busy), .overflow(a_ovf)
  );

  pulse_spacer_fast #(.GAP_CYCLES(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(b_rst), .pulse_in(b_pulse), .flush(b_flush), .clr_ovf(b_clr),
    .pulse_out(b_po), .pending(b_pend), .busy(b_busy), .overflow(b_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string tag);
    int unsigned n = 0;
    while (a_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drain_a: busy=%b after %0d cycles, required 0", tag, a_busy, n);
    end
  endtask

  task automatic drain_b(input string tag);
    int unsigned n = 0;
    while (b_busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (b_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drain_b: busy=%b after %0d cycles, required 0", tag, b_busy, n);
    end
  endtask

  task automatic test_reset();
    a_rst = 1; a_pulse = 0; a_flush = 0; a_clr = 0;
    b_rst = 1; b_pulse = 0; b_flush = 0; b_clr = 0;
    tick();
    tick();
    a_rst = 0; b_rst = 0;
    vectors++;
    if (a_st !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_a: status=%b required %b", a_st, 7'b0);
    end
    vectors++;
    if (b_st !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_b: status=%b required %b", b_st, 5'b0);
    end
  endtask

  task automatic test_single();
    a_pulse = 1;
    tick();
    a_pulse = 0;
    vectors++;
    if (a_st !== 7'b1_0000_1_0) begin
      miscompares++;
      $display("FAIL single_issue: status=%b required %b", a_st, 7'b1_0000_1_0);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if (a_st !== 7'b0_0000_1_0) begin
        miscompares++;
        $display("FAIL single_gap k=%0d: status=%b required %b", k, a_st, 7'b0_0000_1_0);
      end
    end
    tick();
    vectors++;
    if (a_st !== 7'b0) begin
      miscompares++;
      $display("FAIL single_idle: status=%b required %b", a_st, 7'b0);
    end
  endtask

  task automatic test_burst();
    int       pulses = 0;
    int       peak   = 0;
    logic [6:0] exp_st;
    logic       e_po, e_busy;
    int         e_pend;
    for (int k = 0; k < 45; k++) begin
      a_pulse = (k < 5);
      tick();
      e_po   = (k % 8 == 0) && (k <= 32);
      e_pend = (k < 4) ? k : ((k < 32) ? 4 - k / 8 : 0);
      e_busy = (k < 39);
      exp_st = {e_po, 4'(e_pend), e_busy, 1'b0};
      if (a_po) pulses++;
      if (int'(a_pend) > peak) peak = int'(a_pend);
      vectors++;
      if (a_st !== exp_st) begin
        miscompares++;
        $display("FAIL burst k=%0d: status=%b required %b", k, a_st, exp_st);
      end
    end
    a_pulse = 0;
    vectors++;
    if (pulses != 5 || peak != 4) begin
      miscompares++;
      $display("FAIL burst_totals: pulses=%0d peak=%0d required 5 and 4", pulses, peak);
    end
  endtask

  task automatic test_arrival_during_issue();
    a_pulse = 1;
    tick(); tick(); tick();
    a_pulse = 0;
    vectors++;
    if (a_pend !== 4'd2) begin
      miscompares++;
      $display("FAIL arrival_setup: pending=%0d required 2", a_pend);
    end
    repeat (5) tick();
    a_pulse = 1;
    tick();
    a_pulse = 0;
    vectors++;
    if (a_po !== 1'b1 || a_pend !== 4'd2) begin
      miscompares++;
      $display("FAIL arrival_issue: pulse_out=%b pending=%0d required 1 and 2", a_po, a_pend);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      vectors++;
      if (a_po !== 1'b0 || a_pend !== 4'd2) begin
        miscompares++;
        $display("FAIL arrival_gap k=%0d: pulse_out=%b pending=%0d required 0 and 2", k, a_po, a_pend);
      end
    end
    tick();
    vectors++;
    if (a_po !== 1'b1 || a_pend !== 4'd1) begin
      miscompares++;
      $display("FAIL arrival_next: pulse_out=%b pending=%0d required 1 and 1", a_po, a_pend);
    end
    drain_a("arrival");
  endtask

  task automatic test_flush();
    a_pulse = 1;
    repeat (6) tick();
    vectors++;
    if (a_pend !== 4'd5 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup: pending=%0d busy=%b required 5 and 1", a_pend, a_busy);
    end
    a_flush = 1;
    tick();
    a_flush = 0; a_pulse = 0;
    vectors++;
    if (a_st !== 7'b0_0000_1_0) begin
      miscompares++;
      $display("FAIL flush_apply: status=%b required %b", a_st, 7'b0_0000_1_0);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      vectors++;
      if (a_st !== 7'b0) begin
        miscompares++;
        $display("FAIL flush_quiet k=%0d: status=%b required %b", k, a_st, 7'b0);
      end
    end
    a_pulse = 1;
    tick();
    a_pulse = 0;
    vectors++;
    if (a_st !== 7'b1_0000_1_0) begin
      miscompares++;
      $display("FAIL flush_reissue: status=%b required %b", a_st, 7'b1_0000_1_0);
    end
    drain_a("flush");
  endtask

  task automatic test_saturation();
    int pulses = 0;
    b_pulse = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (b_po) pulses++;
    end
    b_pulse = 0;
    vectors++;
    if (b_pend !== 2'd3 || b_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_full: pending=%0d overflow=%b required 3 and 1", b_pend, b_ovf);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (b_po) pulses++;
    end
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("FAIL sat_pulses: pulses=%0d required 4", pulses);
    end
    vectors++;
    if (b_st !== 5'b0_00_0_1) begin
      miscompares++;
      $display("FAIL sat_sticky: status=%b required %b", b_st, 5'b0_00_0_1);
    end
    b_clr = 1;
    tick();
    b_clr = 0;
    vectors++;
    if (b_st !== 5'b0) begin
      miscompares++;
      $display("FAIL sat_clear: status=%b required %b", b_st, 5'b0);
    end

    b_pulse = 1;
    repeat (4) tick();
    vectors++;
    if (b_st !== 5'b0_11_1_0) begin
      miscompares++;
      $display("FAIL flush_full_setup: status=%b required %b", b_st, 5'b0_11_1_0);
    end
    b_flush = 1;
    tick();
    b_flush = 0; b_pulse = 0;
    vectors++;
    if (b_st !== 5'b0_00_1_0) begin
      miscompares++;
      $display("FAIL flush_full: status=%b required %b", b_st, 5'b0_00_1_0);
    end
    drain_b("flush_full");

    b_pulse = 1;
    repeat (4) tick();
    b_clr = 1;
    tick();
    b_pulse = 0;
    vectors++;
    if (b_st !== 5'b0_11_1_1) begin
      miscompares++;
      $display("FAIL set_wins: status=%b required %b", b_st, 5'b0_11_1_1);
    end
    tick();
    b_clr = 0;
    vectors++;
    if (b_st !== 5'b0_11_1_0) begin
      miscompares++;
      $display("FAIL clr_after: status=%b required %b", b_st, 5'b0_11_1_0);
    end
    drain_b("set_wins");
  endtask

  task automatic test_reset_midop();
    a_pulse = 1;
    repeat (20) tick();
    a_pulse = 0;
    vectors++;
    if (a_st !== 7'b0_1111_1_1) begin
      miscompares++;
      $display("FAIL midop_overflow: status=%b required %b", a_st, 7'b0_1111_1_1);
    end
    repeat (4) tick();
    tick();
    vectors++;
    if (a_st !== 7'b1_1110_1_1) begin
      miscompares++;
      $display("FAIL midop_issue: status=%b required %b", a_st, 7'b1_1110_1_1);
    end
    a_rst = 1; a_pulse = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (a_st !== 7'b0) begin
        miscompares++;
        $display("FAIL midop_reset k=%0d: status=%b required %b", k, a_st, 7'b0);
      end
    end
    a_rst = 0; a_pulse = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (a_st !== 7'b0) begin
        miscompares++;
        $display("FAIL midop_after k=%0d: status=%b required %b", k, a_st, 7'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    repeat (2) tick();
    test_burst();
    repeat (2) tick();
    test_arrival_during_issue();
    repeat (2) tick();
    test_flush();
    repeat (2) tick();
    test_saturation();
    repeat (2) tick();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pulse_spacer_fast.md
Name: pulse_spacer_fast

Overview:
Fast-domain pacing stage that sits directly upstream of the fast-to-slow single-bit pulse synchronizer. It accepts arbitrary bursts of single-cycle event pulses and counts them as pending events. It re-issues them as isolated one-cycle pulses spaced at least GAP_CYCLES apart, so the synchronizer's capture and feedback-clear loop finishes before the next event arrives. Events beyond counter capacity are dropped and flagged with a sticky overflow.

Parameters:
GAP_CYCLES, 8, exact spacing in clk cycles between pulse_out rising edges under backlog. Legal range is 2 or more. Size it as at least ceil(3*Tslow/Tfast)+3.
CNT_W, 4, width of the pending-event counter. Capacity is 2^CNT_W-1 events.

Ports:
clk  input  1  fast-domain clock
rst  input  1  synchronous reset, active-high
pulse_in  input  1  event strobe; each cycle high counts as one event
flush  input  1  discards all pending events
clr_ovf  input  1  clears the sticky overflow flag
pulse_out  output  1  registered one-cycle event pulse to the synchronizer input
pending  output  CNT_W  number of events queued and not yet issued
busy  output  1  high while pending!=0 or a gap is running
overflow  output  1  sticky; at least one event was dropped

Behaviour:
- Single clock domain. All state is updated on posedge clk.
- Reset: when rst=1 at an edge, the following are cleared to 0: pulse_out, pending, gap_cnt, overflow. busy=0 after reset. A reset in mid-burst or mid-gap discards everything, and no pulse_out follows.
- Internal gap_cnt has width clog2(GAP_CYCLES).
  - IDLE: gap_cnt==0.
  - GAP: gap_cnt!=0. In this state gap_cnt decrements by 1 each cycle.
- issue = (gap_cnt==0) && !flush && (pending!=0 || pulse_in).
- On issue:
  - pulse_out <= 1 for exactly one cycle.
  - gap_cnt <= GAP_CYCLES-1.
- Otherwise pulse_out <= 0.
- Latency: from IDLE with pending==0, pulse_in high at edge t gives pulse_out high in the cycle after edge t (1 cycle). pending stays 0 (bypass).
- Backlog: successive pulse_out rising edges are exactly GAP_CYCLES cycles apart. pulse_out is never high two cycles in a row.
- Pending update, with inc=pulse_in and dec=issue:
  - inc and dec both set, or neither set: pending unchanged.
  - inc only: pending+1, saturating at 2^CNT_W-1.
  - dec only: pending-1. This cannot underflow, because dec only occurs when pending+inc is at least 1.
- Overflow: pending==2^CNT_W-1 && pulse_in && !issue && !flush. The event is dropped, pending stays at max, and overflow <= 1.
- flush=1:
  - pending <= 0.
  - A pulse_in in the same cycle is discarded without setting overflow.
  - issue is suppressed that cycle.
  - A running gap_cnt continues to count down.
  - A pulse_out already registered high completes normally.
- clr_ovf=1: overflow <= 0. If an overflow condition occurs in the same cycle, set wins and overflow stays 1.
- busy = (pending!=0) || (gap_cnt!=0). busy is combinational from registers.
- Event conservation: issued + dropped + flushed = accepted pulse_in cycles.

Test Plan:
1. Single event: GAP_CYCLES=8, after reset pulse_in=1 for 1 cycle at edge t -> pulse_out=1 only in cycle t+1; pending stays 0; busy high for 7 cycles after issue, then 0.
2. Burst: pulse_in high for 5 consecutive cycles -> 5 pulse_out pulses, rising edges 8 cycles apart; pending peaks at 4 then counts down 4,3,2,1,0; overflow=0.
3. Saturation: CNT_W=2, pulse_in high 6 consecutive cycles -> pending saturates at 3; 1 issued immediately plus 3 queued = 4 pulses total, 2 dropped; overflow=1 until clr_ovf; clr_ovf coinciding with a new drop leaves overflow=1.
4. Arrival during issue: pending=2 with pulse_in=1 on the issue cycle -> pending stays 2; next issue exactly 8 cycles later.
5. Flush: pending=5 mid-gap, flush=1 together with pulse_in=1 -> pending=0 next cycle; no further pulse_out; overflow unchanged; new pulse_in after the gap expires issues normally.
6. Reset mid-operation: rst=1 during a burst with pulse_out high -> the next cycle shows pulse_out=0, pending=0, busy=0, overflow=0; pulse_in held during rst is ignored.
